// File: rtl/johnson_pkg.sv
// Shared types, mode encodings and Johnson-pattern helpers for the sequencer.
// The phase helpers enumerate the 2*WIDTH legal ring patterns in advance order.
package johnson_pkg;

    localparam int JOHNSON_WIDTH = 4;
    localparam int PHASE_W       = $clog2(2 * JOHNSON_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] MODE_CONT     = 2'b00;
    localparam logic [1:0] MODE_COUNT    = 2'b01;
    localparam logic [1:0] MODE_STEP     = 2'b10;
    localparam logic [1:0] MODE_STEP_ALT = 2'b11;

    localparam logic [JOHNSON_WIDTH-1:0] ALL_ONES = '1;

    // Phase k fills ones from the MSB for k <= WIDTH, then drains them from the MSB.
    function automatic logic [JOHNSON_WIDTH-1:0] phase_pattern(input int k);
        logic [JOHNSON_WIDTH-1:0] p;
        if (k <= JOHNSON_WIDTH)
            p = ~(ALL_ONES >> k);
        else
            p = ALL_ONES >> (k - JOHNSON_WIDTH);
        return p;
    endfunction

    function automatic logic phase_legal(input logic [JOHNSON_WIDTH-1:0] pat);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * JOHNSON_WIDTH; k++) begin
            if (pat == phase_pattern(k))
                hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [PHASE_W-1:0] phase_decode(input logic [JOHNSON_WIDTH-1:0] pat);
        logic [PHASE_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < 2 * JOHNSON_WIDTH; k++) begin
            if (pat == phase_pattern(k))
                idx = k[PHASE_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/johnson_ring.sv
// Johnson ring register with preset and legality check; an illegal preset
// lands the ring on the all-zero phase.
module johnson_ring
    import johnson_pkg::*;
#(
    parameter int WIDTH = JOHNSON_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             load_legal
);

    assign load_legal = phase_legal(load_val);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_legal ? load_val : '0;
        else if (advance)
            q <= {~q[0], q[WIDTH-1:1]};
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencing FSM around a Johnson ring: continuous, counted and single-step
// runs, ring preset, and a sticky fault on illegal presets.
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int WIDTH = JOHNSON_WIDTH
)
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [7:0]         run_len,
    input  logic               stop,
    input  logic               load_en,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   Q,
    output logic [PHASE_W-1:0] phase_idx,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic               err
);

    localparam logic [WIDTH-1:0] WRAP_FROM = phase_pattern(2 * JOHNSON_WIDTH - 1);

    state_t     state;
    logic [1:0] mode_q;
    logic [7:0] count;
    logic       advance;
    logic       load;
    logic       load_legal;
    logic       last_step;

    // ready doubles as "IDLE and out of reset", so it gates start and load.
    assign advance   = (state == ST_RUN) && !stop;
    assign load      = (state == ST_IDLE) && ready && load_en;
    assign last_step = mode_q[1] || ((mode_q == MODE_COUNT) && (count == 8'd1));
    assign phase_idx = phase_decode(Q);

    johnson_ring #(.WIDTH(WIDTH)) u_ring (
        .clk        (CLK),
        .reset      (RESET),
        .advance    (advance),
        .load       (load),
        .load_val   (load_val),
        .q          (Q),
        .load_legal (load_legal)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            ready  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            mode_q <= 2'b00;
            count  <= 8'd0;
        end else begin
            done <= 1'b0;
            wrap <= advance && (Q == WRAP_FROM);
            case (state)
                ST_IDLE: begin
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (load_en && !load_legal) begin
                        state <= ST_FAULT;
                        ready <= 1'b0;
                        err   <= 1'b1;
                    end else if (start) begin
                        mode_q <= mode;
                        count  <= run_len;
                        ready  <= 1'b0;
                        if ((mode == MODE_COUNT) && (run_len == 8'd0)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop || last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (mode_q == MODE_COUNT) begin
                        count <= count - 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                ST_FAULT: begin
                    if (err_clr) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios then random stimulus, all
// checked every cycle against a phase-index reference model.
module tb_johnson_seq_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DONE  = 2;
    localparam int S_FAULT = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] run_len = 8'd0;
    logic       stop = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       err_clr = 1'b0;
    logic [3:0] Q;
    logic [2:0] phase_idx;
    logic       ready, busy, done, wrap, err;

    logic [3:0] ringPats [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    int assertions = 0;
    int failures   = 0;

    int mPhase = 0;
    int mState = S_IDLE;
    int mLeft  = 0;
    bit mReady = 0, mBusy = 0, mDone = 0, mWrap = 0, mErr = 0;

    johnson_seq_ctrl #(.WIDTH(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .mode      (mode),
        .run_len   (run_len),
        .stop      (stop),
        .load_en   (load_en),
        .load_val  (load_val),
        .err_clr   (err_clr),
        .Q         (Q),
        .phase_idx (phase_idx),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int patIndex(input logic [3:0] pat);
        int idx;
        idx = -1;
        for (int k = 0; k < 8; k++)
            if (ringPats[k] == pat)
                idx = k;
        return idx;
    endfunction

    // Reference model: ring tracked as a phase number, runs as "advances remaining" (-1 = unbounded).
    task automatic modelStep();
        int hit;
        mDone = 0;
        mWrap = 0;
        if (RESET) begin
            mPhase = 0; mState = S_IDLE; mReady = 0; mLeft = 0; mErr = 0;
        end else begin
            case (mState)
                S_IDLE: begin
                    if (!mReady) begin
                        mReady = 1;
                    end else begin
                        if (load_en) begin
                            hit = patIndex(load_val);
                            if (hit >= 0) begin
                                mPhase = hit;
                            end else begin
                                mPhase = 0; mErr = 1; mState = S_FAULT; mReady = 0;
                            end
                        end
                        if (mState == S_IDLE && start) begin
                            if (mode == 2'd0)      mLeft = -1;
                            else if (mode == 2'd1) mLeft = run_len;
                            else                   mLeft = 1;
                            mReady = 0;
                            if (mLeft == 0) begin
                                mState = S_DONE; mDone = 1;
                            end else begin
                                mState = S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        mState = S_DONE; mDone = 1;
                    end else begin
                        if (mPhase == 7) mWrap = 1;
                        mPhase = (mPhase + 1) % 8;
                        if (mLeft > 0) begin
                            mLeft--;
                            if (mLeft == 0) begin
                                mState = S_DONE; mDone = 1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    mState = S_IDLE; mReady = 1;
                end
                default: begin
                    if (err_clr) begin
                        mState = S_IDLE; mReady = 1; mErr = 0;
                    end
                end
            endcase
        end
        mBusy = (mState == S_RUN);
    endtask

    task automatic checkAll();
        checkOutput("q",         Q,         ringPats[mPhase]);
        checkOutput("phase_idx", phase_idx, mPhase);
        checkOutput("ready",     ready,     mReady);
        checkOutput("busy",      busy,      mBusy);
        checkOutput("done",      done,      mDone);
        checkOutput("wrap",      wrap,      mWrap);
        checkOutput("err",       err,       mErr);
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic [1:0] md,
                                 input logic [7:0] rl, input logic sp, input logic ld,
                                 input logic [3:0] lv, input logic ec);
        RESET = rst; start = st; mode = md; run_len = rl;
        stop = sp; load_en = ld; load_val = lv; err_clr = ec;
        @(posedge CLK);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 2'b00, 8'd0, 0, 0, 4'd0, 0);
    endtask

    initial begin
        // Reset, then counted run of three advances
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        applyStimulus(1, 1, 2'b00, 8'd0, 1, 0, 4'd0, 0);
        idleCycles(1);
        applyStimulus(0, 1, 2'b01, 8'd3, 0, 0, 4'd0, 0);
        idleCycles(4);
        checkOutput("count3_q", Q, 4'b1110);
        checkOutput("count3_ready", ready, 1'b1);

        // Continuous from zero through a full lap, then stop
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        idleCycles(1);
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        idleCycles(9);
        applyStimulus(0, 0, 2'b00, 8'd0, 1, 0, 4'd0, 0);
        idleCycles(2);

        // Preset 0011 then single step; a start during RUN is ignored
        applyStimulus(0, 0, 2'b00, 8'd0, 0, 1, 4'b0011, 0);
        applyStimulus(0, 1, 2'b10, 8'd0, 0, 0, 4'd0, 0);
        applyStimulus(0, 1, 2'b01, 8'd5, 0, 0, 4'd0, 0);
        idleCycles(2);
        checkOutput("step_q", Q, 4'b0001);
        checkOutput("step_phase", phase_idx, 3'd7);

        // Illegal preset with start, then clear
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 1, 4'b1010, 0);
        checkOutput("fault_q", Q, 4'b0000);
        checkOutput("fault_err", err, 1'b1);
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        applyStimulus(0, 1, 2'b01, 8'd2, 1, 0, 4'd0, 0);
        applyStimulus(0, 0, 2'b00, 8'd0, 0, 0, 4'd0, 1);
        checkOutput("clear_ready", ready, 1'b1);

        // Reset in the middle of a continuous run at 1110
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        idleCycles(3);
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 4'd0, 0);
        checkOutput("midreset_q", Q, 4'b0000);
        checkOutput("midreset_done", done, 1'b0);
        idleCycles(1);

        // Counted run of zero, and stop while idle
        applyStimulus(0, 0, 2'b00, 8'd0, 0, 1, 4'b1100, 0);
        applyStimulus(0, 1, 2'b01, 8'd0, 0, 0, 4'd0, 0);
        checkOutput("zero_run_done", done, 1'b1);
        applyStimulus(0, 0, 2'b00, 8'd0, 1, 0, 4'd0, 0);
        applyStimulus(0, 0, 2'b00, 8'd0, 1, 0, 4'd0, 0);
        checkOutput("zero_run_q", Q, 4'b1100);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] lv;
            lv = ($urandom_range(0, 1) == 0) ? ringPats[$urandom_range(0, 7)] : 4'($urandom);
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 3) == 0),
                          2'($urandom),
                          8'($urandom_range(0, 12)),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 7) == 0),
                          lv,
                          ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, ring width; the ring has 2*WIDTH legal phases. WIDTH=4 is the only verified value.
REQ-002 CLK  in  1  sole clock, all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to begin a sequence; sampled only while ready=1.
REQ-005 mode  in  2  sequence mode, latched at start: 00 continuous, 01 counted, 10 single-step, 11 treated as 10.
REQ-006 run_len  in  8  number of phase advances for counted mode, latched at start.
REQ-007 stop  in  1  terminates a continuous or counted run.
REQ-008 load_en  in  1  preset request for the ring; honoured only while ready=1.
REQ-009 load_val  in  WIDTH  pattern loaded when load_en is honoured.
REQ-010 err_clr  in  1  clears err and leaves FAULT.
REQ-011 Q  out  WIDTH  current ring pattern.
REQ-012 phase_idx  out  3  binary phase index of Q: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
REQ-013 ready  out  1  high in IDLE only.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  one-cycle pulse at sequence end.
REQ-016 wrap  out  1  one-cycle pulse on the advance 0001 -> 0000.
REQ-017 err  out  1  sticky illegal-pattern flag.

Function
REQ-018 Advance: Q_next = {~Q[0], Q[WIDTH-1:1]}, one advance per cycle in RUN, no advance in any other state.
REQ-019 States: IDLE, RUN, DONE, FAULT; DONE lasts exactly one cycle, then IDLE.
REQ-020 IDLE: start=1 -> latch mode and run_len, go RUN; first advance occurs on the next edge.
REQ-021 Counted: exactly run_len advances, then DONE; run_len=0 -> IDLE -> DONE directly with no advance.
REQ-022 Single-step: exactly one advance, then DONE.
REQ-023 Continuous: advance every cycle until stop.
REQ-024 stop=1 in RUN: no advance on that edge; go DONE.
REQ-025 stop in IDLE, DONE or FAULT is ignored.
REQ-026 start while not ready is ignored and is not queued.
REQ-027 start and load_en together in IDLE: load applies first and the run starts from load_val; run counting is unchanged.
REQ-028 Legal load_val (one of the 8 patterns): Q = load_val next cycle, stay IDLE.
REQ-029 Illegal load_val: Q forced to 0000, err=1, go FAULT; start is ignored that cycle.
REQ-030 FAULT: ready=0, busy=0; err_clr=1 -> err=0, go IDLE, Q remains 0000.
REQ-031 done asserts in the DONE state; wrap asserts in the cycle after the qualifying edge; both are registered outputs.
REQ-032 phase_idx is a combinational decode of Q and is always consistent with Q.

Reset
REQ-033 RESET=1 at an edge: Q=0000, state IDLE, done=0, wrap=0, err=0, latched mode/run_len=0; this overrides every other input, including mid-run.
REQ-034 ready=0 while RESET is high; ready=1 from the first edge with RESET low.

Structure
REQ-035 Package johnson_pkg holds the state enum, the mode encodings, the WIDTH default, and the legal-pattern/phase-decode function.
REQ-036 Sub-module johnson_ring holds the ring register, the advance/load logic and the legality check; johnson_seq_ctrl holds the FSM and the run counter.

Verification
REQ-037 Reset, then counted with run_len=3 -> Q 1000, 1100, 1110; done pulses once; ready returns 1; wrap=0.
REQ-038 Continuous from 0000 for 9 cycles, then stop -> Q cycles through all 8 patterns; wrap pulses once on 0001 -> 0000; done pulses once.
REQ-039 load_en with 0011, then single-step -> Q=0001, phase_idx=7, done pulses once; a start issued during RUN is ignored.
REQ-040 load_en with 1010 -> Q=0000, err=1, FAULT, start ignored; err_clr -> err=0, ready=1.
REQ-041 RESET mid continuous run at Q=1110 -> next cycle Q=0000, state IDLE, no done pulse.
REQ-042 Counted with run_len=0 -> done pulses with Q unchanged; stop asserted in IDLE has no effect.
